// File: rtl/tt_ctrl_sel_pkg.sv
// Shared defaults and types for the project-select controller.
// Parameter defaults live here so every instantiation site agrees on them.
package tt_ctrl_sel_pkg;

  localparam int TT_SEL_W       = 10;
  localparam int TT_SPINE_BITS  = 1;
  localparam int TT_SPINE_LSB   = 5;
  localparam int TT_SEL_SETTLE  = 4;
  localparam int TT_SYNC_STAGES = 2;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_ACTIVE = 1'b1
  } sel_state_e;

  // A settle window of one cycle still needs a one-bit timer.
  function automatic int timer_width(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/tt_ctrl_sync.sv
// Multi-flop synchroniser for one asynchronous pin, with a rising-edge
// pulse taken from one extra flop behind the synchronised output.
module tt_ctrl_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      q_d   <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      q_d   <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~q_d;

endmodule

// File: rtl/tt_ctrl_sel.sv
// Project-select controller: synchronised pins drive a select counter that is
// split into spine index and address, with a gating window after every change.
module tt_ctrl_sel
  import tt_ctrl_sel_pkg::*;
#(
  parameter int SEL_W       = TT_SEL_W,
  parameter int SPINE_BITS  = TT_SPINE_BITS,
  parameter int SPINE_LSB   = TT_SPINE_LSB,
  parameter int SETTLE      = TT_SEL_SETTLE,
  parameter int SYNC_STAGES = TT_SYNC_STAGES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ctrl_sel_rst_n,
  input  logic                        ctrl_sel_inc,
  input  logic                        ctrl_sel_load,
  input  logic                        ctrl_sel_data,
  input  logic                        ctrl_ena,
  output logic [SEL_W-SPINE_BITS-1:0] sel_addr,
  output logic [SPINE_BITS-1:0]       side_sel,
  output logic [2**SPINE_BITS-1:0]    side_ena,
  output logic                        proj_ena,
  output logic                        busy
);

  localparam int N_SPINE = 2**SPINE_BITS;
  localparam int AW      = SEL_W - SPINE_BITS;
  localparam int TW      = timer_width(SETTLE);
  localparam logic [AW-1:0] LO_MASK = AW'((64'd1 << SPINE_LSB) - 64'd1);

  logic       sel_rst_s, inc_s, load_s, data_s, ena_s;
  logic       step;
  logic [3:0] unused_rise;

  tt_ctrl_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_rst (
    .clk(clk), .rst_n(rst_n), .d(ctrl_sel_rst_n), .q(sel_rst_s), .rise(unused_rise[0]));
  tt_ctrl_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_inc (
    .clk(clk), .rst_n(rst_n), .d(ctrl_sel_inc), .q(inc_s), .rise(step));
  tt_ctrl_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_load (
    .clk(clk), .rst_n(rst_n), .d(ctrl_sel_load), .q(load_s), .rise(unused_rise[1]));
  tt_ctrl_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_data (
    .clk(clk), .rst_n(rst_n), .d(ctrl_sel_data), .q(data_s), .rise(unused_rise[2]));
  tt_ctrl_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ena (
    .clk(clk), .rst_n(rst_n), .d(ctrl_ena), .q(ena_s), .rise(unused_rise[3]));

  logic [SEL_W-1:0] cnt;
  logic             sel_event;

  assign sel_event = step | ~sel_rst_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!sel_rst_s) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= load_s ? {cnt[SEL_W-2:0], data_s} : cnt + SEL_W'(1);
    end
  end

  logic [AW-1:0] addr_hi, addr_lo;

  assign addr_hi  = AW'(cnt >> (SPINE_LSB + SPINE_BITS));
  assign addr_lo  = AW'(cnt) & LO_MASK;
  assign sel_addr = (addr_hi << SPINE_LSB) | addr_lo;
  assign side_sel = cnt[SPINE_LSB +: SPINE_BITS];

  sel_state_e    state, state_nx;
  logic [TW-1:0] timer, timer_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_SETTLE;
      timer <= TW'(SETTLE - 1);
    end else begin
      state <= state_nx;
      timer <= timer_nx;
    end
  end

  // Any selection event restarts the window, even one already in progress.
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    if (sel_event) begin
      state_nx = ST_SETTLE;
      timer_nx = TW'(SETTLE - 1);
    end else if (state == ST_SETTLE) begin
      if (timer == '0) begin
        state_nx = ST_ACTIVE;
      end else begin
        timer_nx = timer - TW'(1);
      end
    end
  end

  logic [N_SPINE-1:0] side_ena_nx;
  logic               proj_ena_nx, busy_nx;

  // Decoding from the next state lets the gate drop on the counter-update edge.
  always_comb begin
    side_ena_nx = '0;
    proj_ena_nx = 1'b0;
    busy_nx     = 1'b1;
    if (state_nx == ST_ACTIVE) begin
      side_ena_nx = N_SPINE'(1) << side_sel;
      proj_ena_nx = ena_s;
      busy_nx     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      side_ena <= '0;
      proj_ena <= 1'b0;
      busy     <= 1'b1;
    end else begin
      side_ena <= side_ena_nx;
      proj_ena <= proj_ena_nx;
      busy     <= busy_nx;
    end
  end

endmodule

// File: tb/tb_tt_ctrl_sel.sv
// Randomised and directed bench for tt_ctrl_sel against a pin-history model.
// The model derives outputs from delayed pin values and cycles since the last event.
module tb_tt_ctrl_sel;

  localparam int SEL_W      = 10;
  localparam int SPINE_BITS = 1;
  localparam int SPINE_LSB  = 5;
  localparam int SETTLE     = 4;
  localparam int STAGES     = 2;
  localparam int N_SPINE    = 2**SPINE_BITS;
  localparam int AW         = SEL_W - SPINE_BITS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_sel_load, ctrl_sel_data, ctrl_ena;
  logic [AW-1:0]         sel_addr;
  logic [SPINE_BITS-1:0] side_sel;
  logic [N_SPINE-1:0]    side_ena;
  logic                  proj_ena, busy;

  tt_ctrl_sel #(
    .SEL_W(SEL_W), .SPINE_BITS(SPINE_BITS), .SPINE_LSB(SPINE_LSB),
    .SETTLE(SETTLE), .SYNC_STAGES(STAGES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ctrl_sel_rst_n(ctrl_sel_rst_n), .ctrl_sel_inc(ctrl_sel_inc),
    .ctrl_sel_load(ctrl_sel_load), .ctrl_sel_data(ctrl_sel_data),
    .ctrl_ena(ctrl_ena),
    .sel_addr(sel_addr), .side_sel(side_sel), .side_ena(side_ena),
    .proj_ena(proj_ena), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // Pin vector layout: [0] sel_rst_n, [1] inc, [2] load, [3] data, [4] ena.
  int         m_cnt;
  int         since_evt;
  logic       m_ena;
  logic [4:0] pin_q[$];
  logic [4:0] s_prev;
  logic       inc_pp;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt     = 0;
    since_evt = 0;
    m_ena     = 1'b0;
    pin_q.delete();
    s_prev    = '0;
    inc_pp    = 1'b0;
  endtask

  task automatic model_edge();
    bit         step, rst_low;
    logic [4:0] s_now;
    step    = s_prev[1] && !inc_pp;
    rst_low = !s_prev[0];
    if (rst_low) m_cnt = 0;
    else if (step) begin
      if (s_prev[2]) m_cnt = ((m_cnt << 1) | int'(s_prev[3])) % (1 << SEL_W);
      else           m_cnt = (m_cnt + 1) % (1 << SEL_W);
    end
    if (rst_low || step) since_evt = 0;
    else if (since_evt < SETTLE) since_evt++;
    m_ena = s_prev[4];
    pin_q.push_back({ctrl_ena, ctrl_sel_data, ctrl_sel_load, ctrl_sel_inc, ctrl_sel_rst_n});
    if (pin_q.size() > STAGES) void'(pin_q.pop_front());
    s_now  = (pin_q.size() == STAGES) ? pin_q[0] : 5'b0;
    inc_pp = s_prev[1];
    s_prev = s_now;
  endtask

  task automatic compareModel();
    bit act;
    int exp_side, exp_addr;
    act      = (since_evt >= SETTLE);
    exp_side = (m_cnt >> SPINE_LSB) % N_SPINE;
    exp_addr = (m_cnt >> (SPINE_LSB + SPINE_BITS)) * (1 << SPINE_LSB) + m_cnt % (1 << SPINE_LSB);
    checkOutput("sel_addr", 32'(sel_addr), 32'(exp_addr));
    checkOutput("side_sel", 32'(side_sel), 32'(exp_side));
    checkOutput("side_ena", 32'(side_ena), act ? 32'(1 << exp_side) : 32'd0);
    checkOutput("proj_ena", 32'(proj_ena), 32'(act && m_ena));
    checkOutput("busy",     32'(busy),     32'(!act));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    else       model_reset();
    #1;
    compareModel();
  endtask

  task automatic applyStimulus(input logic srst, input logic inc, input logic ld,
                               input logic dat, input logic ena);
    ctrl_sel_rst_n = srst;
    ctrl_sel_inc   = inc;
    ctrl_sel_load  = ld;
    ctrl_sel_data  = dat;
    ctrl_ena       = ena;
  endtask

  task automatic pulse(input logic ld, input logic dat);
    applyStimulus(ctrl_sel_rst_n, 1'b0, ld, dat, ctrl_ena);
    repeat (3) tick();
    ctrl_sel_inc = 1'b1;
    repeat (3) tick();
    ctrl_sel_inc = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, g;
    logic [AW-1:0] addr0;
    logic [9:0] bits;

    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #12;
    checkOutput("rst_busy",     32'(busy),     32'd1);
    checkOutput("rst_side_ena", 32'(side_ena), 32'd0);
    checkOutput("rst_sel_addr", 32'(sel_addr), 32'd0);
    compareModel();

    // Reset release: busy through five edges, active on the sixth.
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checkOutput("release_busy", 32'(busy), 32'd1);
    end
    tick();
    checkOutput("release_busy6",     32'(busy),     32'd0);
    checkOutput("release_side_ena6", 32'(side_ena), 32'h1);
    checkOutput("release_addr6",     32'(sel_addr), 32'd0);

    // Enable toggle while active: three-edge latency, no gating.
    ctrl_ena = 1'b1;
    tick(); checkOutput("ena_e1", 32'(proj_ena), 32'd0);
    tick(); checkOutput("ena_e2", 32'(proj_ena), 32'd0);
    tick(); checkOutput("ena_e3", 32'(proj_ena), 32'd1);
    checkOutput("ena_busy", 32'(busy), 32'd0);
    ctrl_ena = 1'b0;
    repeat (3) tick();
    checkOutput("ena_off", 32'(proj_ena), 32'd0);
    ctrl_ena = 1'b1;

    // Steps while the counter reset pin is low are swallowed.
    ctrl_sel_rst_n = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, 1'b0);
      checkOutput("hold_busy", 32'(busy),     32'd1);
      checkOutput("hold_addr", 32'(sel_addr), 32'd0);
    end
    ctrl_sel_rst_n = 1'b1;
    repeat (8) tick();

    for (int i = 0; i < 32; i++) pulse(1'b0, 1'b0);
    repeat (4) tick();
    checkOutput("inc32_side_sel", 32'(side_sel), 32'd1);
    checkOutput("inc32_addr",     32'(sel_addr), 32'd0);
    checkOutput("inc32_side_ena", 32'(side_ena), 32'h2);

    // Gate shape of one increment from the active state.
    addr0 = sel_addr;
    ctrl_sel_inc = 1'b1;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (sel_addr != addr0) begin n = i; break; end
    end
    ctrl_sel_inc = 1'b0;
    checkOutput("step_latency", 32'(n), 32'd3);
    g = (side_ena == '0) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (side_ena == '0) g++;
      else break;
    end
    checkOutput("gate_len", 32'(g), 32'd4);
    repeat (3) tick();

    // Second step two cycles into the window extends the gate.
    ctrl_sel_inc = 1'b1; tick();
    ctrl_sel_inc = 1'b0; tick();
    ctrl_sel_inc = 1'b1; tick();
    ctrl_sel_inc = 1'b0;
    repeat (5) tick();
    checkOutput("dbl_busy8", 32'(busy), 32'd1);
    tick();
    checkOutput("dbl_busy9", 32'(busy), 32'd0);

    bits = 10'b1010000011;
    for (int i = 9; i >= 0; i--) pulse(1'b1, bits[i]);
    repeat (5) tick();
    checkOutput("load_addr",     32'(sel_addr), 32'h143);
    checkOutput("load_side_sel", 32'(side_sel), 32'd0);

    // Asynchronous reset in the middle of a settle window.
    pulse(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_addr",     32'(sel_addr), 32'd0);
    checkOutput("arst_side_sel", 32'(side_sel), 32'd0);
    checkOutput("arst_side_ena", 32'(side_ena), 32'd0);
    checkOutput("arst_proj_ena", 32'(proj_ena), 32'd0);
    checkOutput("arst_busy",     32'(busy),     32'd1);
    model_reset();
    tick();
    rst_n = 1'b1;
    repeat (8) tick();

    for (int i = 0; i < 10; i++) pulse(1'b1, 1'b1);
    repeat (5) tick();
    checkOutput("ones_addr", 32'(sel_addr), 32'h1FF);
    pulse(1'b0, 1'b0);
    repeat (5) tick();
    checkOutput("wrap_addr",     32'(sel_addr), 32'd0);
    checkOutput("wrap_side_sel", 32'(side_sel), 32'd0);

    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(0, 19) != 0), ($urandom_range(0, 2) == 0),
                    1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
